// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the bubble instruction and the
// instruction-fetch state encoding.
package pipe_pkg;

    localparam int PC_W = 16;
    localparam int IR_W = 32;

    localparam logic [IR_W-1:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ     = 2'b00,
        FS_WAIT    = 2'b01,
        FS_DISCARD = 2'b10
    } fetch_state_e;

    // Sequential PC advance; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                   input logic [PC_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_out_slot.sv
// Single-entry {PC, IR, valid} holding register between the fetch logic and IF/ID.
// Flush beats load, load beats consume; IR falls back to the bubble value whenever the entry empties.
module if_out_slot
    import pipe_pkg::*;
#(
    parameter logic [IR_W-1:0] NOP_VAL = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic [IR_W-1:0] load_ir,
    input  logic            consume,
    input  logic            flush,
    output logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] ir,
    output logic            valid
);

    logic [PC_W-1:0] pc_r;
    logic [IR_W-1:0] ir_r;
    logic            valid_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [IR_W-1:0] ir_nxt_s;
    logic            valid_nxt_s;

    // Next-entry selection.
    always_comb begin
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        valid_nxt_s = valid_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
            ir_nxt_s    = NOP_VAL;
        end else if (load) begin
            pc_nxt_s    = load_pc;
            ir_nxt_s    = load_ir;
            valid_nxt_s = 1'b1;
        end else if (consume) begin
            valid_nxt_s = 1'b0;
            ir_nxt_s    = NOP_VAL;
        end else begin
            pc_nxt_s    = pc_r;
            ir_nxt_s    = ir_r;
            valid_nxt_s = valid_r;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r    <= {PC_W{1'b0}};
            ir_r    <= NOP_VAL;
            valid_r <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign pc    = pc_r;
    assign ir    = ir_r;
    assign valid = valid_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch in flight and
// hands {PC, IR} to the IF/ID register through a single-entry output slot.
module if_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd4,
    parameter logic [IR_W-1:0] NOP_INSN = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_freeze,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [IR_W-1:0] i_imem_rdata,
    output logic [PC_W-1:0] o_PC,
    output logic [IR_W-1:0] o_IR,
    output logic            o_valid,
    output logic            o_flush
);

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [PC_W-1:0] fetch_pc_r;
    logic [PC_W-1:0] fetch_pc_nxt_s;
    logic [PC_W-1:0] seq_pc_s;
    logic [PC_W-1:0] inflight_pc_r;
    logic            armed_r;
    logic            flush_r;
    logic            slot_valid_s;
    logic            consume_s;
    logic            slot_free_s;
    logic            issue_s;
    logic            load_s;

    assign consume_s   = slot_valid_s & ~i_freeze;
    assign slot_free_s = ~slot_valid_s | consume_s;
    // A fetch only leaves when its response is guaranteed room in the slot,
    // so a returning word never has to be refused.
    assign o_imem_req  = armed_r & (state_r == FS_REQ) & slot_free_s;
    assign o_imem_addr = fetch_pc_r;
    assign issue_s     = o_imem_req & i_imem_gnt;
    assign load_s      = (state_r == FS_WAIT) & i_imem_rvalid & ~i_redirect & slot_free_s;
    assign o_valid     = slot_valid_s;
    assign o_flush     = flush_r;

    // Fetch FSM next state and PC selection; redirect overrides everything.
    always_comb begin
        state_nxt_s    = state_r;
        seq_pc_s       = fetch_pc_r;
        fetch_pc_nxt_s = fetch_pc_r;
        case (state_r)
            FS_REQ: begin
                if (issue_s) begin
                    seq_pc_s    = pc_advance(fetch_pc_r, PC_STEP);
                    state_nxt_s = i_redirect ? FS_DISCARD : FS_WAIT;
                end else begin
                    state_nxt_s = FS_REQ;
                end
            end
            FS_WAIT: begin
                // A response landing on the redirect edge retires the fetch itself.
                if (i_redirect) begin
                    state_nxt_s = i_imem_rvalid ? FS_REQ : FS_DISCARD;
                end else if (load_s) begin
                    state_nxt_s = FS_REQ;
                end else begin
                    state_nxt_s = FS_WAIT;
                end
            end
            FS_DISCARD: begin
                if (i_imem_rvalid) begin
                    state_nxt_s = FS_REQ;
                end else begin
                    state_nxt_s = FS_DISCARD;
                end
            end
            default: begin
                state_nxt_s = FS_REQ;
            end
        endcase
        if (i_redirect) begin
            fetch_pc_nxt_s = i_redirect_pc;
        end else begin
            fetch_pc_nxt_s = seq_pc_s;
        end
    end

    // FSM state, PC and flush registers; armed_r holds off the first request for one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= FS_REQ;
            fetch_pc_r <= RESET_PC;
            armed_r    <= 1'b0;
            flush_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            armed_r    <= 1'b1;
            flush_r    <= i_redirect;
        end
    end

    // Address of the fetch in flight, tagged onto its returning word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_pc_r <= {PC_W{1'b0}};
        end else if (issue_s) begin
            inflight_pc_r <= fetch_pc_r;
        end else begin
            inflight_pc_r <= inflight_pc_r;
        end
    end

    if_out_slot #(
        .NOP_VAL (NOP_INSN)
    ) u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .load_pc (inflight_pc_r),
        .load_ir (i_imem_rdata),
        .consume (consume_s),
        .flush   (i_redirect),
        .pc      (o_PC),
        .ir      (o_IR),
        .valid   (slot_valid_s)
    );

endmodule
